// File: rtl/fetch_prefetch.sv
// Instruction prefetch buffer: drives read port 1 of the shared memory and
// queues PC-tagged instructions for decode behind a valid/ready handshake.
module fetch_prefetch #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              r_en1,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] r_data1,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [UW-1:0] used;

    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight_q & ~redirect;

    // Credit: a slot must exist for every outstanding read, net of this pop.
    assign used  = UW'(count_q) + UW'(inflight_q) - UW'(pop);
    assign issue = ~reset & ~redirect & ~halt & (used < UW'(DEPTH));
    assign r_en1 = issue;
    assign addr1 = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        data_d        = data_q;
        pc_d          = pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                data_d[wr_ptr_q] = r_data1;
                pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        pc_q   <= pc_d;
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: directed scenarios push expected
// {instr, pc} pairs; a negedge monitor pops them on every accepted handshake.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r_en1;
    logic [15:0] addr1;
    logic [15:0] r_data1 = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] pc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_prefetch dut (
        .clk        (clk),
        .reset      (reset),
        .r_en1      (r_en1),
        .addr1      (addr1),
        .r_data1    (r_data1),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    function automatic logic [15:0] memval(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            16'h0003: return 16'h4444;
            default:  return a ^ 16'hBEEF;
        endcase
    endfunction

    // One-cycle-latency memory model.
    always @(posedge clk) begin
        if (r_en1) r_data1 <= memval(addr1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h instr %h expected none",
                         instr_pc, instr);
            end else begin
                mon_e = q.pop_front();
                chk("pop_instr", {16'h0, instr}, {16'h0, mon_e.d});
                chk("pop_pc", {16'h0, instr_pc}, {16'h0, mon_e.pc});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_range(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            q.push_back({memval(a), a});
        end
    endtask

    task automatic start(input logic rdy, input logic hlt);
        reset       = 1'b1;
        redirect    = 1'b0;
        halt        = hlt;
        instr_ready = rdy;
        q.delete();
        tick;
        @(negedge clk);
        chk("rst_r_en1", {31'h0, r_en1}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        tick;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 20; k++) begin
            if (!instr_valid && q.size() == 0) break;
            tick;
        end
        chk({nm, "_left"}, q.size(), 0);
        chk({nm, "_valid"}, {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Streaming from reset, ready high
        start(1'b1, 1'b0);
        exp_range(16'h0000, 4);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_en0", {31'h0, r_en1}, 32'h1);
        chk("t1_a0", {16'h0, addr1}, 32'h0);
        chk("t1_v0", {31'h0, instr_valid}, 32'h0);
        tick;
        @(negedge clk);
        chk("t1_a1", {16'h0, addr1}, 32'h1);
        chk("t1_v1", {31'h0, instr_valid}, 32'h0);
        tick;
        @(negedge clk);
        chk("t1_a2", {16'h0, addr1}, 32'h2);
        chk("t1_v2", {31'h0, instr_valid}, 32'h1);
        tick;
        @(negedge clk);
        chk("t1_a3", {16'h0, addr1}, 32'h3);
        tick;
        halt = 1'b1;
        @(negedge clk);
        chk("t1_halt_en", {31'h0, r_en1}, 32'h0);
        drain("t1");

        // Fill with ready low, then full-rate streaming
        start(1'b0, 1'b0);
        exp_range(16'h0000, 12);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_en", {31'h0, r_en1}, 32'h1);
            chk("t2_addr", {16'h0, addr1}, 32'(i));
            tick;
        end
        @(negedge clk);
        chk("t2_stop", {31'h0, r_en1}, 32'h0);
        tick;
        @(negedge clk);
        chk("t2_stop2", {31'h0, r_en1}, 32'h0);
        chk("t2_hold_i", {16'h0, instr}, 32'h1111);
        chk("t2_hold_pc", {16'h0, instr_pc}, 32'h0);
        tick;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_resume_en", {31'h0, r_en1}, 32'h1);
        chk("t2_resume_a", {16'h0, addr1}, 32'h4);
        repeat (8) tick;
        halt = 1'b1;
        drain("t5");

        // Redirect with a read in flight
        start(1'b1, 1'b0);
        exp_range(16'h0000, 2);
        exp_range(16'h0040, 2);
        reset = 1'b0;
        repeat (3) tick;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        chk("t3_no_issue", {31'h0, r_en1}, 32'h0);
        tick;
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_flushed", {31'h0, instr_valid}, 32'h0);
        chk("t3_en", {31'h0, r_en1}, 32'h1);
        chk("t3_addr", {16'h0, addr1}, 32'h40);
        repeat (2) tick;
        halt = 1'b1;
        drain("t3");

        // Address wrap
        start(1'b1, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        exp_range(16'hFFFF, 3);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_no_issue", {31'h0, r_en1}, 32'h0);
        tick;
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_aFFFF", {16'h0, addr1}, 32'hFFFF);
        tick;
        @(negedge clk);
        chk("t4_a0000", {16'h0, addr1}, 32'h0);
        tick;
        @(negedge clk);
        chk("t4_a0001", {16'h0, addr1}, 32'h1);
        tick;
        halt = 1'b1;
        drain("t4");

        // Reset mid-stream, then halt drain and resume
        start(1'b0, 1'b0);
        reset = 1'b0;
        repeat (4) tick;
        chk("t6_pre_valid", {31'h0, instr_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_rst_en", {31'h0, r_en1}, 32'h0);
        tick;
        exp_range(16'h0000, 3);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_first_en", {31'h0, r_en1}, 32'h1);
        chk("t6_first_a", {16'h0, addr1}, 32'h0);
        repeat (3) tick;
        halt        = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_halt_en", {31'h0, r_en1}, 32'h0);
            tick;
        end
        chk("t6_drained", {31'h0, instr_valid}, 32'h0);
        chk("t6_left", q.size(), 0);
        halt = 1'b0;
        #1;
        chk("t6_resume_en", {31'h0, r_en1}, 32'h1);
        chk("t6_resume_a", {16'h0, addr1}, 32'h3);
        halt = 1'b1;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
